// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory-port arbiter.
//   port_id_e  : which requester owns a grant or a response
//   OOR_DATA   : read data returned for an out-of-range access
//   rsp_rec_t  : response record captured at grant time
//   word_in_range : true when a byte address falls inside the SRAM
package mem_arb_pkg;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

    localparam logic [31:0] OOR_DATA = 32'hDEADBEEF;

    typedef struct packed {
        port_id_e owner;
        logic     is_write;
        logic     oor;
    } rsp_rec_t;

    // Byte address is in range when its word index is below the SRAM depth.
    function automatic logic word_in_range(input logic [31:0] byte_addr,
                                           input int unsigned words);
        return ({2'b00, byte_addr[31:2]} < 32'(words));
    endfunction

endpackage

// File: rtl/mem_arb_checker.sv
// mem_arb_checker
// Protocol monitor: a request that has not yet been granted must stay
// asserted with unchanged address/data/enables on the next cycle.
//   clk, rst_n                      : clock and reset
//   i_req, i_addr, i_gnt            : fetch port
//   d_req, d_addr, d_wdata, d_wen, d_gnt : data port
module mem_arb_checker (
    input logic        clk,
    input logic        rst_n,
    input logic        i_req,
    input logic [31:0] i_addr,
    input logic        i_gnt,
    input logic        d_req,
    input logic [31:0] d_addr,
    input logic [31:0] d_wdata,
    input logic [3:0]  d_wen,
    input logic        d_gnt
);

    logic        i_pend_q;
    logic        d_pend_q;
    logic [31:0] i_addr_q;
    logic [31:0] d_addr_q;
    logic [31:0] d_wdata_q;
    logic [3:0]  d_wen_q;

    // Remember last cycle's ungranted requests and compare against this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_pend_q  <= 1'b0;
            d_pend_q  <= 1'b0;
            i_addr_q  <= 32'h0;
            d_addr_q  <= 32'h0;
            d_wdata_q <= 32'h0;
            d_wen_q   <= 4'h0;
        end else begin
            if (i_pend_q) begin
                a_i_hold: assert (i_req && (i_addr == i_addr_q));
            end
            if (d_pend_q) begin
                a_d_hold: assert (d_req && (d_addr == d_addr_q) &&
                                  (d_wdata == d_wdata_q) && (d_wen == d_wen_q));
            end
            i_pend_q  <= i_req && !i_gnt;
            d_pend_q  <= d_req && !d_gnt;
            i_addr_q  <= i_addr;
            d_addr_q  <= d_addr;
            d_wdata_q <= d_wdata;
            d_wen_q   <= d_wen;
        end
    end

endmodule

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Winner selection between the fetch and data requesters.
//   clk, rst_n     : clock and synchronous active-low reset
//   i_req, d_req   : pending requests
//   i_win, d_win   : one-hot grant (both 0 while in reset or idle)
// Holds the fetch starvation counter and the last conflict winner used
// by the round-robin mode.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int RR_MODE  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    output logic i_win,
    output logic d_win
);

    localparam int WCW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;

    logic [WCW-1:0] wait_cnt_q;
    logic [WCW-1:0] wait_cnt_d;
    port_id_e       last_win_q;
    port_id_e       last_win_d;
    logic           fetch_first_s;

    // Arbitration, starvation counter and round-robin pointer next state.
    always_comb begin
        i_win      = 1'b0;
        d_win      = 1'b0;
        last_win_d = last_win_q;
        wait_cnt_d = {WCW{1'b0}};

        if (RR_MODE != 0) begin
            // Loser of the previous conflict goes first.
            fetch_first_s = (last_win_q == PORT_D);
        end else begin
            fetch_first_s = (wait_cnt_q == WCW'(MAX_WAIT));
        end

        if (!rst_n) begin
            i_win = 1'b0;
            d_win = 1'b0;
        end else if (i_req && d_req) begin
            i_win      = fetch_first_s;
            d_win      = !fetch_first_s;
            last_win_d = fetch_first_s ? PORT_I : PORT_D;
        end else begin
            i_win = i_req;
            d_win = d_req;
        end

        // Counts consecutive lost cycles of a pending fetch.
        if (i_req && !i_win) begin
            if (wait_cnt_q != {WCW{1'b1}}) begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = {WCW{1'b0}};
        end
    end

    // State registers with synchronous reset; last winner resets to data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= {WCW{1'b0}};
            last_win_q <= PORT_D;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            last_win_q <= last_win_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous SRAM between the CPU fetch and data ports.
//   clk, rst_n                 : clock, synchronous active-low reset
//   i_req/i_addr/i_gnt         : fetch request handshake
//   i_rvalid/i_rdata           : fetch response (cycle after i_gnt)
//   d_req/d_addr/d_wdata/d_wen/d_gnt : data request handshake (d_wen=0 load)
//   d_rvalid/d_rdata/d_err     : data response; d_err flags out-of-range
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : SRAM macro interface
//   conflict_cnt               : saturating count of cycles with both requests
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10,
    parameter int MAX_WAIT  = 4,
    parameter int RR_MODE   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wen,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   conflict_cnt
);

    logic        i_win_s;
    logic        d_win_s;
    logic [31:0] g_addr_s;
    logic        in_range_s;

    logic        rsp_vld_q;
    logic        rsp_vld_d;
    rsp_rec_t    rsp_q;
    rsp_rec_t    rsp_d;
    logic [15:0] conflict_cnt_q;
    logic [15:0] conflict_cnt_d;

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .RR_MODE  (RR_MODE)
    ) u_pick (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (i_req),
        .d_req (d_req),
        .i_win (i_win_s),
        .d_win (d_win_s)
    );

    mem_arb_checker u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wen   (d_wen),
        .d_gnt   (d_gnt)
    );

    // Grant outputs and SRAM drive for the winning port; pick is already reset-gated.
    always_comb begin
        i_gnt      = i_win_s;
        d_gnt      = d_win_s;
        g_addr_s   = d_win_s ? d_addr : i_addr;
        in_range_s = word_in_range(g_addr_s, MEM_WORDS);
        mem_en     = (i_win_s || d_win_s) && in_range_s;
        mem_addr   = g_addr_s[AW+1:2];
        mem_wdata  = d_wdata;
        if (d_win_s && in_range_s) begin
            mem_we = d_wen;
        end else begin
            mem_we = 4'b0000;
        end
    end

    // Response record and conflict counter next state.
    always_comb begin
        rsp_vld_d      = i_win_s || d_win_s;
        rsp_d.owner    = d_win_s ? PORT_D : PORT_I;
        rsp_d.is_write = d_win_s && (d_wen != 4'b0000);
        rsp_d.oor      = !in_range_s;
        if (i_req && d_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end else begin
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Response and counter registers; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q      <= 1'b0;
            rsp_q          <= '{owner: PORT_I, is_write: 1'b0, oor: 1'b0};
            conflict_cnt_q <= 16'h0000;
        end else begin
            rsp_vld_q      <= rsp_vld_d;
            rsp_q          <= rsp_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Response decode: SRAM data arrives in this cycle, so rdata is steered, not stored.
    always_comb begin
        i_rvalid     = rsp_vld_q && (rsp_q.owner == PORT_I);
        d_rvalid     = rsp_vld_q && (rsp_q.owner == PORT_D);
        d_err        = d_rvalid && rsp_q.oor;
        conflict_cnt = conflict_cnt_q;
        if (!i_rvalid) begin
            i_rdata = 32'h0;
        end else if (rsp_q.oor) begin
            i_rdata = OOR_DATA;
        end else begin
            i_rdata = mem_rdata;
        end
        if (!d_rvalid) begin
            d_rdata = 32'h0;
        end else if (rsp_q.oor) begin
            d_rdata = OOR_DATA;
        end else if (rsp_q.is_write) begin
            d_rdata = 32'h0;
        end else begin
            d_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural SRAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wen;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] conflict_cnt;

    logic [31:0] sram [0:1023];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int n_vec;
    int n_err;

    mem_port_arbiter #(
        .MEM_WORDS (1024),
        .AW        (10),
        .MAX_WAIT  (4),
        .RR_MODE   (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wen        (d_wen),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: byte-enabled write, registered read; ld_* preloads words.
    always @(posedge clk) begin
        if (ld_en) begin
            sram[ld_addr] <= ld_data;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] v);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = v;
        next_cyc();
        ld_en   = 1'b0;
    endtask

    task automatic idle();
        i_req = 1'b0; d_req = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wen = 4'h0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ld_en = 1'b0; ld_addr = 10'd0; ld_data = 32'h0;
        mem_rdata = 32'h0;
        idle();
        next_cyc();
        preload(10'd0,  32'h0000_0000);
        preload(10'd2,  32'h1111_1111);
        preload(10'd4,  32'h00A0_0093);
        preload(10'd64, 32'h0000_0000);
        preload(10'd65, 32'hFFFF_FFFF);

        // Reset: grants and SRAM strobes forced low even with requests up.
        i_req = 1'b1; d_req = 1'b1; d_wen = 4'hF; #1;
        check_val("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
        check_val("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        check_val("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check_val("rst_mem_we", {28'b0, mem_we}, 32'd0);
        check_val("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
        check_val("rst_ccnt", {16'b0, conflict_cnt}, 32'd0);
        next_cyc();
        idle();
        rst_n = 1'b1;
        next_cyc();

        // 1: fetch only.
        i_req = 1'b1; i_addr = 32'h10; #1;
        check_val("t1_i_gnt", {31'b0, i_gnt}, 32'd1);
        check_val("t1_mem_en", {31'b0, mem_en}, 32'd1);
        check_val("t1_mem_addr", {22'b0, mem_addr}, 32'd4);
        next_cyc();
        idle(); #1;
        check_val("t1_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check_val("t1_i_rdata", i_rdata, 32'h00A0_0093);
        next_cyc();

        // 2: conflict, data first.
        d_req = 1'b1; d_addr = 32'h100; d_wen = 4'hF; d_wdata = 32'd240;
        i_req = 1'b1; i_addr = 32'h0; #1;
        check_val("t2_gnts", {30'b0, i_gnt, d_gnt}, 32'd1);
        check_val("t2_mem_we", {28'b0, mem_we}, 32'hF);
        check_val("t2_mem_addr", {22'b0, mem_addr}, 32'd64);
        next_cyc();
        d_req = 1'b0; d_wen = 4'h0; #1;
        check_val("t2_i_gnt", {31'b0, i_gnt}, 32'd1);
        check_val("t2_st_ack", {31'b0, d_rvalid}, 32'd1);
        check_val("t2_st_rdata", d_rdata, 32'h0);
        next_cyc();
        i_req = 1'b0;
        d_req = 1'b1; d_addr = 32'h100; d_wen = 4'h0; #1;
        check_val("t2_i_rvalid", {31'b0, i_rvalid}, 32'd1);
        check_val("t2_ld_gnt", {31'b0, d_gnt}, 32'd1);
        next_cyc();
        idle(); #1;
        check_val("t2_ld_rdata", d_rdata, 32'd240);
        check_val("t2_ccnt", {16'b0, conflict_cnt}, 32'd1);
        next_cyc();

        // 3: starvation guard, fetch forced on the 5th conflicting cycle.
        for (int k = 1; k <= 8; k++) begin
            i_req = (k <= 5); i_addr = 32'h8;
            d_req = 1'b1; d_addr = 32'h100; d_wen = 4'h0; #1;
            check_val($sformatf("t3_gnt_c%0d", k), {30'b0, i_gnt, d_gnt},
                      (k == 5) ? 32'd2 : 32'd1);
            if (k == 6) begin
                check_val("t3_i_rdata", i_rdata, 32'h1111_1111);
            end
            next_cyc();
        end
        // Counter cleared: a fresh conflict goes to data again.
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; #1;
        check_val("t3_wait_clr", {30'b0, i_gnt, d_gnt}, 32'd1);
        next_cyc();
        d_req = 1'b0; #1;
        check_val("t3_i_after", {31'b0, i_gnt}, 32'd1);
        next_cyc();
        idle(); #1;
        check_val("t3_ccnt", {16'b0, conflict_cnt}, 32'd7);
        next_cyc();

        // 4: byte store then readback.
        d_req = 1'b1; d_addr = 32'h104; d_wen = 4'b0001; d_wdata = 32'hAA; #1;
        check_val("t4_mem_we", {28'b0, mem_we}, 32'h1);
        next_cyc();
        d_wen = 4'b0000; d_wdata = 32'h0; #1;
        check_val("t4_ack", {31'b0, d_rvalid}, 32'd1);
        check_val("t4_ack_rdata", d_rdata, 32'h0);
        next_cyc();
        idle(); #1;
        check_val("t4_rdback", d_rdata, 32'hFFFF_FFAA);
        next_cyc();

        // 5: out of range, load then store.
        d_req = 1'b1; d_addr = 32'h1000; d_wen = 4'h0; #1;
        check_val("t5_gnt", {31'b0, d_gnt}, 32'd1);
        check_val("t5_mem_en", {31'b0, mem_en}, 32'd0);
        next_cyc();
        d_wen = 4'hF; d_wdata = 32'h1234_5678; #1;
        check_val("t5_err", {31'b0, d_err}, 32'd1);
        check_val("t5_rdata", d_rdata, 32'hDEAD_BEEF);
        check_val("t5_st_en_we", {27'b0, mem_en, mem_we}, 32'd0);
        next_cyc();
        idle();
        i_req = 1'b1; i_addr = 32'h2000; #1;
        check_val("t5_st_err", {31'b0, d_err}, 32'd1);
        check_val("t5_st_rdata", d_rdata, 32'hDEAD_BEEF);
        check_val("t5_i_mem_en", {31'b0, mem_en}, 32'd0);
        next_cyc();
        idle(); #1;
        check_val("t5_i_rdata", i_rdata, 32'hDEAD_BEEF);
        check_val("t5_i_noerr", {31'b0, d_err}, 32'd0);
        check_val("t5_sram0", sram[0], 32'h0);
        next_cyc();

        // 6: reset asserted just before the edge closing a data grant.
        d_req = 1'b1; d_addr = 32'h100; d_wen = 4'h0; #1;
        check_val("t6_gnt", {31'b0, d_gnt}, 32'd1);
        #3;
        rst_n = 1'b0;
        next_cyc();
        i_req = 1'b1; d_req = 1'b1; #1;
        check_val("t6_no_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
        check_val("t6_gnts_low", {30'b0, i_gnt, d_gnt}, 32'd0);
        check_val("t6_ccnt", {16'b0, conflict_cnt}, 32'd0);
        next_cyc();
        idle();
        rst_n = 1'b1;
        next_cyc();
        d_req = 1'b1; d_addr = 32'h104; #1;
        check_val("t6_post_gnt", {31'b0, d_gnt}, 32'd1);
        next_cyc();
        idle(); #1;
        check_val("t6_post_rvalid", {31'b0, d_rvalid}, 32'd1);
        check_val("t6_post_rdata", d_rdata, 32'hFFFF_FFAA);
        next_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous SRAM between the CPU instruction-fetch port and the data port. Each port uses a req/gnt handshake with the response one cycle after the grant. Sits between cpu_top's i_mem_*/d_mem_* interfaces and a unified memory macro, replacing separate instruction and data memories. Provides starvation protection for fetch, an out-of-range response, and a saturating conflict counter for performance tests.

Parameters:
MEM_WORDS, 1024, SRAM depth in 32-bit words; byte addresses >= 4*MEM_WORDS are out of range.
AW, 10, SRAM word-address width (clog2(MEM_WORDS)).
MAX_WAIT, 4, maximum consecutive cycles a pending fetch may lose arbitration before it is forced.
RR_MODE, 0, 0 = data-priority with starvation guard; 1 = round-robin on conflict.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
i_req  in  1  fetch request; held with i_addr stable until i_gnt.
i_addr  in  32  fetch byte address; bits [1:0] ignored.
i_gnt  out  1  fetch accepted this cycle.
i_rvalid  out  1  fetch data valid; one cycle after i_gnt.
i_rdata  out  32  fetch data.
d_req  in  1  data request; held stable until d_gnt.
d_addr  in  32  data byte address; bits [1:0] ignored.
d_wdata  in  32  store data.
d_wen  in  4  byte enables; 4'b0000 = load.
d_gnt  out  1  data request accepted this cycle.
d_rvalid  out  1  load data valid or store ack; one cycle after d_gnt.
d_rdata  out  32  load data; 0 on a store ack.
d_err  out  1  qualifies d_rvalid; access was out of range.
mem_en  out  1  SRAM enable.
mem_we  out  4  SRAM byte write enables.
mem_addr  out  AW  SRAM word address.
mem_wdata  out  32  SRAM write data.
mem_rdata  in  32  SRAM read data, valid the cycle after mem_en.
conflict_cnt  out  16  saturating count of cycles with i_req && d_req.

Behaviour:
- Reset: synchronous, active-low; clk single clock.
  - Reset clears: i_rvalid, d_rvalid, d_err, i_rdata, d_rdata, conflict_cnt, wait_cnt, last_conflict_winner (= data), and the response-owner register.
  - While rst_n == 0: i_gnt, d_gnt, mem_en and mem_we are forced to 0.
- Arbitration (combinational, same cycle):
  - Only one request pending: it is granted.
  - Both pending, RR_MODE == 0: data wins unless wait_cnt == MAX_WAIT, in which case fetch wins.
  - Both pending, RR_MODE == 1: the loser of the previous conflict wins.
- wait_cnt (3+ bits) increments each cycle i_req && !i_gnt, and clears on i_gnt or !i_req.
- Grant drives the SRAM in the same cycle:
  - mem_en = 1 when the granted address is in range.
  - mem_addr = addr[AW+1:2].
  - mem_we = d_wen for a data grant, 0 for a fetch grant.
  - mem_wdata = d_wdata.
- Out-of-range grant: still granted. mem_en = 0 and any store is dropped. The response cycle returns rdata 32'hDEADBEEF; d_err = 1 on the data port (the fetch port has no error flag).
- Response register: records owner, write flag and range flag at grant. The next cycle pulses exactly one of i_rvalid/d_rvalid for one cycle, with rdata = mem_rdata, 0 (store) or DEADBEEF.
- Throughput: back-to-back grants every cycle; a response and a new grant may coincide.
- conflict_cnt increments on i_req && d_req and saturates at 16'hFFFF.
- Reset mid-operation: a response pending at the reset edge is dropped (no rvalid); requesters reissue.
- Requests that change before gnt are protocol violations; behaviour is undefined and a simulation assertion is required.

Decomposition:
- Shared package mem_arb_pkg:
  - port-ID enum {PORT_I, PORT_D}
  - constant OOR_DATA = 32'hDEADBEEF
  - response-record typedef {owner, is_write, oor}
- One sub-module, mem_arb_pick, holds the winner selection, wait_cnt and the round-robin pointer. The top handles SRAM muxing, the response register and counters.

Test Plan:
1. Fetch only: SRAM word 4 = 0x00A00093; i_req with i_addr 0x10 -> same cycle i_gnt=1, mem_en=1, mem_addr=4; next cycle i_rvalid=1, i_rdata=0x00A00093.
2. Conflict, RR_MODE=0: d store 0x100, wen 4'hF, data 240, alongside i_req 0x0 -> d_gnt first, i_gnt next cycle; later d load 0x100 -> d_rdata=240; conflict_cnt=1.
3. Starvation, MAX_WAIT=4: d_req held 8 cycles with i_req held -> i_gnt in cycle 5, d resumes in cycle 6; wait_cnt returns to 0.
4. Byte store: word 0x104 = 0xFFFFFFFF, d_wen=4'b0001, d_wdata=0xAA -> store ack d_rdata=0; readback = 0xFFFFFFAA.
5. Out of range: d load 0x1000 (MEM_WORDS=1024) -> mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0xDEADBEEF; a store to the same address leaves the SRAM unchanged.
6. Reset mid-access: rst_n=0 sampled at the edge ending a d_gnt cycle -> no d_rvalid afterwards; conflict_cnt=0, gnts=0 while reset is low; the first request after release is serviced normally.
